seven_segment_scan_driver: RTL and testbench

Parametrised, time-multiplexed driver for a common-anode seven-segment bank of `DIGITS` digits. It replaces the fixed four-digit scanner and adds:
- a programmable scan rate;
- per-digit decimal point and blanking;
- a 16-level brightness PWM;
- frame-synchronous double-buffered loading, so that updated values never tear mid-frame.

It sits between the clock/time datapath and the board segment/anode pins.

---
 rtl/seven_segment_scan_driver.sv | 120 ++++++++++++
 tb/tb_seven_segment_scan_driver.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_driver.sv
`default_nettype none
// seven_segment_scan_driver: multiplexed common-anode 7-segment driver with PWM, DP/blank and frame-synchronous shadow load.
// Optional feature macro: SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN (automatic leading-zero blanking).
module seven_segment_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIVIDER = 1000
) (
  input  logic                displayClock,
  input  logic                resetN,
  input  logic [4*DIGITS-1:0] digitData,
  input  logic [DIGITS-1:0]   decimalPoints,
  input  logic [DIGITS-1:0]   digitBlank,
  input  logic                loadStrobe,
  input  logic [3:0]          brightness,
  output logic [DIGITS-1:0]   sevenSegmentEnable,
  output logic [7:0]          sevenSegmentData,
  output logic                frameStart,
  output logic                loadPending
);
  localparam int c_CNT_W  = $clog2(SCAN_DIVIDER);
  localparam int c_IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int c_DUTY_W = 4 + c_CNT_W + 1;
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(SCAN_DIVIDER - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DIGITS - 1);

  logic [c_CNT_W-1:0]     slotCount_q, slotCount_d;
  logic [c_IDX_W-1:0]     digitIndex_q, digitIndex_d;
  logic [DIGITS-1:0][3:0] shadowNib_q;
  logic [DIGITS-1:0]      shadowDp_q, shadowBlank_q;
  logic                   loadPending_q, loadPending_d;
  logic                   wrapped_q, frameStart_q;
  logic [DIGITS-1:0]      enable_q, enable_d;
  logic [7:0]             data_q, data_d;

  logic                   w_terminal, w_boundary, w_doLoad;
  logic [DIGITS-1:0]      w_blankEff;
  logic [c_DUTY_W-1:0]    w_dutyLimit;

  function automatic logic [7:0] decode(input logic [3:0] v);
    case (v)
      4'h0: return 8'h11;  4'h1: return 8'hD7;  4'h2: return 8'h32;  4'h3: return 8'h92;
      4'h4: return 8'hD4;  4'h5: return 8'h98;  4'h6: return 8'h18;  4'h7: return 8'hD3;
      4'h8: return 8'h10;  4'h9: return 8'h90;  4'hA: return 8'h50;  4'hB: return 8'h1C;
      4'hC: return 8'h39;  4'hD: return 8'h16;  4'hE: return 8'h38;  default: return 8'h78;
    endcase
  endfunction

  always_comb begin
    w_terminal    = (slotCount_q == c_LAST_CNT);
    w_boundary    = w_terminal && (digitIndex_q == c_LAST_IDX);
    w_doLoad      = w_boundary && (loadPending_q || loadStrobe);
    loadPending_d = w_doLoad ? 1'b0 : (loadPending_q || loadStrobe);
    slotCount_d   = w_terminal ? '0 : slotCount_q + 1'b1;
    digitIndex_d  = digitIndex_q;
    if (w_terminal)
      digitIndex_d = (digitIndex_q == c_LAST_IDX) ? '0 : digitIndex_q + 1'b1;
  end

  always_comb begin : p_blank
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    logic higherZero;
`endif
    w_blankEff = shadowBlank_q;
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    // Walk from the most-significant digit down; digit 0 is never auto-blanked.
    higherZero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (higherZero && (shadowNib_q[i] == 4'h0) && !shadowDp_q[i])
        w_blankEff[i] = 1'b1;
      higherZero = higherZero && ((shadowNib_q[i] == 4'h0) || shadowBlank_q[i]);
    end
`endif
  end

  always_comb begin
    w_dutyLimit = ((c_DUTY_W'(brightness) + c_DUTY_W'(1)) * c_DUTY_W'(SCAN_DIVIDER)) >> 4;
    data_d      = 8'hFF;
    if (!w_blankEff[digitIndex_q])
      data_d = decode(shadowNib_q[digitIndex_q]) & (shadowDp_q[digitIndex_q] ? 8'hEF : 8'hFF);
    enable_d = '1;
    // Slot count 0 is the first cycle on a new digit: keep all anodes off to avoid ghosting.
    if (!w_blankEff[digitIndex_q] && (slotCount_q != '0) &&
        ({{(c_DUTY_W - c_CNT_W){1'b0}}, slotCount_q} < w_dutyLimit))
      enable_d[digitIndex_q] = 1'b0;
  end

  always_ff @(posedge displayClock or negedge resetN) begin
    if (!resetN) begin
      slotCount_q   <= '0;
      digitIndex_q  <= '0;
      shadowNib_q   <= '0;
      shadowDp_q    <= '0;
      shadowBlank_q <= '1;
      loadPending_q <= 1'b0;
      wrapped_q     <= 1'b0;
      frameStart_q  <= 1'b0;
      enable_q      <= '1;
      data_q        <= 8'hFF;
    end else begin
      slotCount_q   <= slotCount_d;
      digitIndex_q  <= digitIndex_d;
      loadPending_q <= loadPending_d;
      wrapped_q     <= w_boundary;
      frameStart_q  <= wrapped_q;
      enable_q      <= enable_d;
      data_q        <= data_d;
      if (w_doLoad) begin
        shadowNib_q   <= digitData;
        shadowDp_q    <= decimalPoints;
        shadowBlank_q <= digitBlank;
      end
    end
  end

  assign sevenSegmentEnable = enable_q;
  assign sevenSegmentData   = data_q;
  assign frameStart         = frameStart_q;
  assign loadPending        = loadPending_q;
endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan_driver.sv
`default_nettype none
// tb_seven_segment_scan_driver: cycle scoreboard for the seven-segment scan driver (DIGITS=4, SCAN_DIVIDER=32).
module tb_seven_segment_scan_driver;
  localparam int D     = 4;
  localparam int SD    = 32;
  localparam int FRAME = D * SD;

  logic           clk    = 1'b0;
  logic           rstN   = 1'b1;
  logic [4*D-1:0] dData  = '0;
  logic [D-1:0]   dps    = '0;
  logic [D-1:0]   blanks = '0;
  logic           strobe = 1'b0;
  logic [3:0]     bright = 4'd15;
  logic [D-1:0]   en;
  logic [7:0]     seg;
  logic           fs, lp;

  seven_segment_scan_driver #(.DIGITS(D), .SCAN_DIVIDER(SD)) dut (
    .displayClock(clk), .resetN(rstN), .digitData(dData), .decimalPoints(dps),
    .digitBlank(blanks), .loadStrobe(strobe), .brightness(bright),
    .sevenSegmentEnable(en), .sevenSegmentData(seg), .frameStart(fs), .loadPending(lp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [D-1:0] en;
    logic [7:0]   seg;
    logic         fs;
    logic         lp;
  } out_t;
  localparam out_t RESET_OUT = '{en: {D{1'b1}}, seg: 8'hFF, fs: 1'b0, lp: 1'b0};

  int         vectors = 0;
  int         errors  = 0;
  int         cyc;
  logic [3:0] mNib [D];
  logic [D-1:0] mDp, mBlank;
  logic       mPend;
  out_t       expq[$];
  out_t       got, want;

  function automatic logic [7:0] segOf(input logic [3:0] v);
    case (v)
      4'h0: return 8'h11;  4'h1: return 8'hD7;  4'h2: return 8'h32;  4'h3: return 8'h92;
      4'h4: return 8'hD4;  4'h5: return 8'h98;  4'h6: return 8'h18;  4'h7: return 8'hD3;
      4'h8: return 8'h10;  4'h9: return 8'h90;  4'hA: return 8'h50;  4'hB: return 8'h1C;
      4'hC: return 8'h39;  4'hD: return 8'h16;  4'hE: return 8'h38;  default: return 8'h78;
    endcase
  endfunction

  function automatic logic [D-1:0] effBlank();
    logic [D-1:0] b;
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    logic hz;
`endif
    b = mBlank;
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    hz = 1'b1;
    for (int i = D - 1; i >= 1; i--) begin
      if (hz && mNib[i] == 4'h0 && !mDp[i]) b[i] = 1'b1;
      hz = hz && (mNib[i] == 4'h0 || mBlank[i]);
    end
`endif
    return b;
  endfunction

  task automatic reset_model();
    cyc = 0;
    for (int i = 0; i < D; i++) mNib[i] = 4'h0;
    mDp    = '0;
    mBlank = '1;
    mPend  = 1'b0;
    expq.delete();
    expq.push_back(RESET_OUT);
  endtask

  // Output in cycle cyc+1 reflects the state of cycle cyc: slot position and digit follow from cyc.
  task automatic advance();
    out_t e;
    int s, d, duty;
    logic [D-1:0] b;
    s    = cyc % SD;
    d    = (cyc / SD) % D;
    b    = effBlank();
    duty = ((int'(bright) + 1) * SD) >> 4;
    e.en  = '1;
    e.seg = b[d] ? 8'hFF : (segOf(mNib[d]) & (mDp[d] ? 8'hEF : 8'hFF));
    if (s != 0 && s < duty && !b[d]) e.en[d] = 1'b0;
    e.fs = (cyc != 0) && (cyc % FRAME == 0);
    if ((cyc % FRAME) == FRAME - 1 && (mPend || strobe)) begin
      for (int i = 0; i < D; i++) mNib[i] = dData[4*i +: 4];
      mDp    = dps;
      mBlank = blanks;
      mPend  = 1'b0;
    end else if (strobe) begin
      mPend = 1'b1;
    end
    e.lp = mPend;
    expq.push_back(e);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    #1 rstN = 1'b0;
    #1;
    got = {en, seg, fs, lp}; vectors++;
    if (got !== RESET_OUT) begin
      errors++;
      $display("FAIL reset_state got=%h expected=%h", got, RESET_OUT);
    end
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    reset_model();
    dData = 16'h1234;
    for (int i = 0; i < FRAME + 8; i++) begin
      got = {en, seg, fs, lp}; want = expq.pop_front(); vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_dark cyc=%0d got en=%b seg=%h fs=%b lp=%b expected en=%b seg=%h fs=%b lp=%b",
                 cyc, got.en, got.seg, got.fs, got.lp, want.en, want.seg, want.fs, want.lp);
      end
      advance();
    end
  endtask

  task automatic test_basic_scan();
    int fsCount = 0;
    dData = 16'h1234; bright = 4'd15; blanks = '0; dps = '0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      got = {en, seg, fs, lp}; want = expq.pop_front(); vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL basic_scan cyc=%0d got en=%b seg=%h fs=%b lp=%b expected en=%b seg=%h fs=%b lp=%b",
                 cyc, got.en, got.seg, got.fs, got.lp, want.en, want.seg, want.fs, want.lp);
      end
      if (fs) fsCount++;
      strobe = (i == 0);
      advance();
    end
    strobe = 1'b0;
    vectors++;
    if (fsCount !== 3) begin
      errors++;
      $display("FAIL frame_start_count got=%0d expected=3", fsCount);
    end
  endtask

  task automatic test_frame_load();
    bit done = 0;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      got = {en, seg, fs, lp}; want = expq.pop_front(); vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL frame_load cyc=%0d got en=%b seg=%h fs=%b lp=%b expected en=%b seg=%h fs=%b lp=%b",
                 cyc, got.en, got.seg, got.fs, got.lp, want.en, want.seg, want.fs, want.lp);
      end
      if (i == 5)  dData = 16'h5555;
      if (i == 20) dData = 16'hABCD;
      strobe = (i == 5) || (i == 20);
      advance();
    end
    // Strobe in the boundary cycle itself with nothing pending.
    for (int i = 0; i < 2 * FRAME; i++) begin
      got = {en, seg, fs, lp}; want = expq.pop_front(); vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL coincident_load cyc=%0d got en=%b seg=%h fs=%b lp=%b expected en=%b seg=%h fs=%b lp=%b",
                 cyc, got.en, got.seg, got.fs, got.lp, want.en, want.seg, want.fs, want.lp);
      end
      strobe = !done && ((cyc % FRAME) == FRAME - 1);
      if (strobe) begin dData = 16'h8888; done = 1; end
      advance();
    end
    strobe = 1'b0;
  endtask

  task automatic test_brightness();
    int lows;
    logic [3:0] levels [2];
    int required [2];
    levels[0] = 4'd0; required[0] = 4;
    levels[1] = 4'd7; required[1] = 60;
    for (int l = 0; l < 2; l++) begin
      lows = 0;
      bright = levels[l];
      for (int i = 0; i < 2 * FRAME; i++) begin
        got = {en, seg, fs, lp}; want = expq.pop_front(); vectors++;
        if (got !== want) begin
          errors++;
          $display("FAIL brightness cyc=%0d got en=%b seg=%h fs=%b lp=%b expected en=%b seg=%h fs=%b lp=%b",
                   cyc, got.en, got.seg, got.fs, got.lp, want.en, want.seg, want.fs, want.lp);
        end
        if (i >= FRAME) lows += D - $countones(en);
        advance();
      end
      vectors++;
      if (lows !== required[l]) begin
        errors++;
        $display("FAIL brightness_lows level=%0d got=%0d expected=%0d", levels[l], lows, required[l]);
      end
    end
    for (int i = 0; i < FRAME; i++) begin
      got = {en, seg, fs, lp}; want = expq.pop_front(); vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL brightness_sweep cyc=%0d got en=%b seg=%h fs=%b lp=%b expected en=%b seg=%h fs=%b lp=%b",
                 cyc, got.en, got.seg, got.fs, got.lp, want.en, want.seg, want.fs, want.lp);
      end
      bright = 4'((i * 5) % 16);
      advance();
    end
    bright = 4'd15;
  endtask

  task automatic test_blank_dp();
    int d2Lows = 0, d0Lows = 0, d0Bad = 0;
    dData = 16'h1238; blanks = 4'b0100; dps = 4'b0001;
    for (int i = 0; i < 3 * FRAME; i++) begin
      got = {en, seg, fs, lp}; want = expq.pop_front(); vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL blank_dp cyc=%0d got en=%b seg=%h fs=%b lp=%b expected en=%b seg=%h fs=%b lp=%b",
                 cyc, got.en, got.seg, got.fs, got.lp, want.en, want.seg, want.fs, want.lp);
      end
      if (i >= 2 * FRAME) begin
        if (!en[2]) d2Lows++;
        if (!en[0]) begin d0Lows++; if (seg !== 8'h00) d0Bad++; end
      end
      strobe = (i == 0);
      advance();
    end
    strobe = 1'b0;
    vectors++;
    if (d2Lows !== 0 || d0Lows !== SD - 1 || d0Bad !== 0) begin
      errors++;
      $display("FAIL blank_dp_counts got d2=%0d d0=%0d bad=%0d expected d2=0 d0=%0d bad=0",
               d2Lows, d0Lows, d0Bad, SD - 1);
    end
    blanks = '0; dps = '0;
  endtask

  task automatic test_async_reset();
    repeat (SD + 7) begin
      got = {en, seg, fs, lp}; want = expq.pop_front(); vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL pre_reset cyc=%0d got en=%b seg=%h fs=%b lp=%b expected en=%b seg=%h fs=%b lp=%b",
                 cyc, got.en, got.seg, got.fs, got.lp, want.en, want.seg, want.fs, want.lp);
      end
      advance();
    end
    #2 rstN = 1'b0;
    #1;
    got = {en, seg, fs, lp}; vectors++;
    if (got !== RESET_OUT) begin
      errors++;
      $display("FAIL async_reset got=%h expected=%h", got, RESET_OUT);
    end
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    reset_model();
    dData = 16'h4321;
    for (int i = 0; i < FRAME + 10; i++) begin
      got = {en, seg, fs, lp}; want = expq.pop_front(); vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got en=%b seg=%h fs=%b lp=%b expected en=%b seg=%h fs=%b lp=%b",
                 cyc, got.en, got.seg, got.fs, got.lp, want.en, want.seg, want.fs, want.lp);
      end
      advance();
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] values [2];
    values[0] = 16'h0050;
    values[1] = 16'h0000;
    blanks = '0; dps = '0;
    for (int v = 0; v < 2; v++) begin
      dData = values[v];
      for (int i = 0; i < 2 * FRAME; i++) begin
        got = {en, seg, fs, lp}; want = expq.pop_front(); vectors++;
        if (got !== want) begin
          errors++;
          $display("FAIL leading_zero cyc=%0d got en=%b seg=%h fs=%b lp=%b expected en=%b seg=%h fs=%b lp=%b",
                   cyc, got.en, got.seg, got.fs, got.lp, want.en, want.seg, want.fs, want.lp);
        end
        strobe = (i == 3);
        advance();
      end
      strobe = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_frame_load();
    test_brightness();
    test_blank_dp();
    test_async_reset();
    test_leading_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire
